lib_switch_onehot_buffered: RTL and testbench

//  Parametrised RADIX x RADIX one-hot crossbar with a DEPTH-entry output FIFO on every output port.

---
 rtl/lib_switch_onehot_buffered.sv | 166 ++++++++++++++++
 tb/tb_lib_switch_onehot_buffered.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lib_switch_onehot_buffered.sv
// ============================================================================
// Module   : lib_switch_onehot_buffered
// Brief    : RADIX x RADIX one-hot crossbar, DEPTH-entry FIFO per output port,
//            fixed-priority collision arbitration, sticky protocol-error flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lib_switch_onehot_buffered #(
    parameter int RADIX = 5,
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RADIX-1:0][WIDTH-1:0]   i_data,
    input  logic [RADIX-1:0]              i_valid,
    input  logic [RADIX-1:0][RADIX-1:0]   i_sel,
    output logic [RADIX-1:0]              o_ack,
    output logic [RADIX-1:0][WIDTH-1:0]   o_data,
    output logic [RADIX-1:0]              o_valid,
    input  logic [RADIX-1:0]              i_ready,
    output logic                          o_conflict,
    output logic                          o_sel_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [RADIX-1:0]            w_onehot;
    logic [RADIX-1:0][RADIX-1:0] w_grant_m;
    logic [RADIX-1:0]            w_space_m;
    logic [RADIX-1:0]            w_multi_m;
    logic                        r_conflict;
    logic                        r_sel_err;

    always_comb begin
        for (int n = 0; n < RADIX; n++) begin
            w_onehot[n] = $onehot(i_sel[n]);
        end
    end

    // A winner is acknowledged only when its target FIFO can take the flit.
    always_comb begin
        o_ack = '0;
        for (int m = 0; m < RADIX; m++) begin
            o_ack = o_ack | (w_grant_m[m] & {RADIX{w_space_m[m]}});
        end
        if (reset) begin
            o_ack = '0;
        end
    end

    genvar gm;
    generate
        for (gm = 0; gm < RADIX; gm++) begin : g_out
            logic [RADIX-1:0]   w_req;
            logic [RADIX-1:0]   w_grant;
            logic               w_found;
            logic               w_multi;
            logic               w_pop;
            logic               w_space;
            logic               w_push;
            logic [WIDTH-1:0]   w_push_data;
            logic [c_PTR_W-1:0] w_rd_next;
            logic [WIDTH-1:0]   r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_CNT_W-1:0] r_count;
            logic [WIDTH-1:0]   r_head;

            // Fixed priority: the lowest-index requester takes the output.
            always_comb begin
                w_req       = '0;
                w_grant     = '0;
                w_found     = 1'b0;
                w_multi     = 1'b0;
                w_push_data = '0;
                for (int n = 0; n < RADIX; n++) begin
                    w_req[n] = i_valid[n] & w_onehot[n] & i_sel[n][gm];
                    if (w_req[n]) begin
                        if (w_found) begin
                            w_multi = 1'b1;
                        end else begin
                            w_found     = 1'b1;
                            w_grant[n]  = 1'b1;
                            w_push_data = i_data[n];
                        end
                    end
                end
            end

            assign w_pop     = (r_count != c_CNT_ZERO) && i_ready[gm];
            assign w_space   = (r_count != c_CNT_FULL) || w_pop;
            assign w_push    = w_found && w_space;
            assign w_rd_next = r_rd_ptr + 1'b1;

            assign w_grant_m[gm] = w_grant;
            assign w_space_m[gm] = w_space;
            assign w_multi_m[gm] = w_multi;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                    r_head   <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= w_rd_next;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + 1'b1;
                    end else if (!w_push && w_pop) begin
                        r_count <= r_count - 1'b1;
                    end
                    // The head register keeps its last value once the FIFO drains.
                    if (w_pop) begin
                        if (r_count > c_CNT_ONE) begin
                            r_head <= r_mem[w_rd_next];
                        end else if (w_push) begin
                            r_head <= w_push_data;
                        end
                    end else if ((r_count == c_CNT_ZERO) && w_push) begin
                        r_head <= w_push_data;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_push && !reset) begin
                    r_mem[r_wr_ptr] <= w_push_data;
                end
            end

            assign o_valid[gm] = (r_count != c_CNT_ZERO);
            assign o_data[gm]  = r_head;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            if (|w_multi_m) begin
                r_conflict <= 1'b1;
            end
            if (|(i_valid & ~w_onehot)) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign o_conflict = r_conflict;
    assign o_sel_err  = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_lib_switch_onehot_buffered.sv
// ============================================================================
// Module   : tb_lib_switch_onehot_buffered
// Brief    : Directed self-checking bench for lib_switch_onehot_buffered.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lib_switch_onehot_buffered;

    localparam int RADIX = 5;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic                        clk;
    logic                        reset;
    logic [RADIX-1:0][WIDTH-1:0] i_data;
    logic [RADIX-1:0]            i_valid;
    logic [RADIX-1:0][RADIX-1:0] i_sel;
    logic [RADIX-1:0]            o_ack;
    logic [RADIX-1:0][WIDTH-1:0] o_data;
    logic [RADIX-1:0]            o_valid;
    logic [RADIX-1:0]            i_ready;
    logic                        o_conflict;
    logic                        o_sel_err;

    int checks = 0;
    int errors = 0;

    lib_switch_onehot_buffered #(
        .RADIX (RADIX),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_sel      (i_sel),
        .o_ack      (o_ack),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_conflict (o_conflict),
        .o_sel_err  (o_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = '0;
        i_sel   = '0;
        i_data  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_ready = '1;
        reset   = 1'b1;
        i_valid = 5'b00001;
        i_sel[0] = 5'b00001;
        #2;
        checks++;
        if (o_ack !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ack: got %b expected %b", o_ack, 5'b00000);
        end
        step(); step(); step();
        reset = 1'b0;
        clear_inputs();
        step();
        checks++;
        if (o_valid !== 5'b00000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected %b", o_valid, 5'b00000);
        end
        for (int m = 0; m < RADIX; m++) begin
            checks++;
            if (o_data[m] !== 64'd0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got %h expected 0", m, o_data[m]);
            end
        end
        checks++;
        if ({o_conflict, o_sel_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00", {o_conflict, o_sel_err});
        end
        checks++;
        if (o_ack !== 5'b00000) begin
            errors++;
            $display("FAIL idle_ack: got %b expected %b", o_ack, 5'b00000);
        end
    endtask

    task automatic test_sweep();
        logic [RADIX-1:0] exp_ack;
        logic [WIDTH-1:0] exp_data;
        i_ready = '1;
        for (int n = 0; n < RADIX; n++) begin
            for (int m = 0; m < RADIX; m++) begin
                clear_inputs();
                exp_ack    = RADIX'(1) << n;
                exp_data   = WIDTH'(n * 16 + m);
                i_valid[n] = 1'b1;
                i_sel[n]   = RADIX'(1) << m;
                i_data[n]  = exp_data;
                #1;
                checks++;
                if (o_ack !== exp_ack) begin
                    errors++;
                    $display("FAIL sweep_ack n=%0d m=%0d: got %b expected %b", n, m, o_ack, exp_ack);
                end
                step();
                clear_inputs();
                checks++;
                if (o_valid !== (RADIX'(1) << m)) begin
                    errors++;
                    $display("FAIL sweep_valid n=%0d m=%0d: got %b expected %b", n, m, o_valid, RADIX'(1) << m);
                end
                checks++;
                if (o_data[m] !== exp_data) begin
                    errors++;
                    $display("FAIL sweep_data n=%0d m=%0d: got %h expected %h", n, m, o_data[m], exp_data);
                end
                step();
            end
        end
        checks++;
        if ({o_conflict, o_sel_err} !== 2'b00) begin
            errors++;
            $display("FAIL sweep_flags: got %b expected 00", {o_conflict, o_sel_err});
        end
    endtask

    task automatic test_conflict();
        i_ready  = '1;
        clear_inputs();
        i_valid  = 5'b01010;
        i_sel[1] = 5'b00100;
        i_sel[3] = 5'b00100;
        i_data[1] = 64'hA;
        i_data[3] = 64'hB;
        #1;
        checks++;
        if (o_ack !== 5'b00010) begin
            errors++;
            $display("FAIL conflict_ack0: got %b expected %b", o_ack, 5'b00010);
        end
        step();
        checks++;
        if (o_conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_flag: got %b expected 1", o_conflict);
        end
        i_valid = 5'b01000;
        #1;
        checks++;
        if (o_ack !== 5'b01000) begin
            errors++;
            $display("FAIL conflict_ack1: got %b expected %b", o_ack, 5'b01000);
        end
        checks++;
        if (o_valid[2] !== 1'b1 || o_data[2] !== 64'hA) begin
            errors++;
            $display("FAIL conflict_first: got v=%b d=%h expected v=1 d=a", o_valid[2], o_data[2]);
        end
        step();
        clear_inputs();
        checks++;
        if (o_valid[2] !== 1'b1 || o_data[2] !== 64'hB) begin
            errors++;
            $display("FAIL conflict_second: got v=%b d=%h expected v=1 d=b", o_valid[2], o_data[2]);
        end
        step();
        checks++;
        if (o_valid !== 5'b00000) begin
            errors++;
            $display("FAIL conflict_drain: got %b expected %b", o_valid, 5'b00000);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_out [6];
        for (int k = 0; k < 6; k++) exp_out[k] = 64'h40 + WIDTH'(k);
        i_ready  = 5'b11110;
        clear_inputs();
        i_valid  = 5'b10000;
        i_sel[4] = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            i_data[4] = exp_out[k];
            #1;
            checks++;
            if (o_ack !== 5'b10000) begin
                errors++;
                $display("FAIL bp_fill_ack k=%0d: got %b expected %b", k, o_ack, 5'b10000);
            end
            step();
        end
        i_data[4] = exp_out[4];
        #1;
        checks++;
        if (o_ack !== 5'b00000) begin
            errors++;
            $display("FAIL bp_full_ack: got %b expected %b", o_ack, 5'b00000);
        end
        step();
        checks++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== exp_out[0]) begin
            errors++;
            $display("FAIL bp_head: got v=%b d=%h expected v=1 d=%h", o_valid[0], o_data[0], exp_out[0]);
        end
        i_ready = '1;
        for (int k = 4; k < 6; k++) begin
            i_data[4] = exp_out[k];
            #1;
            checks++;
            if (o_ack !== 5'b10000) begin
                errors++;
                $display("FAIL bp_pushpop_ack k=%0d: got %b expected %b", k, o_ack, 5'b10000);
            end
            step();
            checks++;
            if (o_data[0] !== exp_out[k-3]) begin
                errors++;
                $display("FAIL bp_pushpop_data k=%0d: got %h expected %h", k, o_data[0], exp_out[k-3]);
            end
        end
        clear_inputs();
        for (int k = 3; k < 6; k++) begin
            step();
            checks++;
            if (o_valid[0] !== 1'b1 || o_data[0] !== exp_out[k]) begin
                errors++;
                $display("FAIL bp_drain k=%0d: got v=%b d=%h expected v=1 d=%h", k, o_valid[0], o_data[0], exp_out[k]);
            end
        end
        step();
        checks++;
        if (o_valid[0] !== 1'b0 || o_data[0] !== exp_out[5]) begin
            errors++;
            $display("FAIL bp_empty: got v=%b d=%h expected v=0 d=%h", o_valid[0], o_data[0], exp_out[5]);
        end
    endtask

    task automatic test_sel_err();
        logic [RADIX-1:0] bad_sel [2];
        bad_sel[0] = 5'b00110;
        bad_sel[1] = 5'b00000;
        i_ready = '1;
        checks++;
        if (o_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_pre: got %b expected 0", o_sel_err);
        end
        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            i_valid[2] = 1'b1;
            i_sel[2]   = bad_sel[k];
            i_data[2]  = 64'hDEAD;
            #1;
            checks++;
            if (o_ack !== 5'b00000) begin
                errors++;
                $display("FAIL sel_err_ack k=%0d: got %b expected %b", k, o_ack, 5'b00000);
            end
            step();
            checks++;
            if (o_sel_err !== 1'b1) begin
                errors++;
                $display("FAIL sel_err_flag k=%0d: got %b expected 1", k, o_sel_err);
            end
            checks++;
            if (o_valid !== 5'b00000) begin
                errors++;
                $display("FAIL sel_err_enq k=%0d: got %b expected %b", k, o_valid, 5'b00000);
            end
        end
        clear_inputs();
        step();
        checks++;
        if (o_sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_sticky: got %b expected 1", o_sel_err);
        end
    endtask

    task automatic test_mid_reset();
        i_ready  = 5'b11101;
        clear_inputs();
        i_valid  = 5'b00001;
        i_sel[0] = 5'b00010;
        for (int k = 0; k < 3; k++) begin
            i_data[0] = 64'h10 + WIDTH'(k);
            step();
        end
        checks++;
        if (o_valid[1] !== 1'b1 || o_data[1] !== 64'h10) begin
            errors++;
            $display("FAIL mid_fill: got v=%b d=%h expected v=1 d=10", o_valid[1], o_data[1]);
        end
        reset = 1'b1;
        i_data[0] = 64'h13;
        #1;
        checks++;
        if (o_ack !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset_ack: got %b expected %b", o_ack, 5'b00000);
        end
        step();
        reset = 1'b0;
        clear_inputs();
        checks++;
        if (o_valid !== 5'b00000 || o_data[1] !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got v=%b d=%h expected v=00000 d=0", o_valid, o_data[1]);
        end
        checks++;
        if ({o_conflict, o_sel_err} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b expected 00", {o_conflict, o_sel_err});
        end
        i_ready = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (o_valid !== 5'b00000) begin
                errors++;
                $display("FAIL mid_reset_stale k=%0d: got %b expected %b", k, o_valid, 5'b00000);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_ready = '1;
        clear_inputs();
        test_reset();
        test_sweep();
        test_conflict();
        test_backpressure();
        test_sel_err();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
